// File: rtl/mmu_pager_pkg.sv
// mmu_pager shared definitions: PTE layout, fault codes, FSM states.
// Build option: MMIO_FAR_EN maps the fault status register into slot 15.
package mmu_pkg;

  localparam int PTE_V      = 0;
  localparam int PTE_W      = 1;
  localparam int PTE_U      = 2;
  localparam int PTE_D      = 3;
  localparam int PPN_LSB    = 8;
  localparam int PAGE_SHIFT = 12;

  typedef enum logic [1:0] {
    FC_NONE = 2'b00,
    FC_INV  = 2'b01,
    FC_WP   = 2'b10,
    FC_PRIV = 2'b11
  } fault_cause_e;

  typedef enum logic {
    IDLE,
    FAULTED
  } pf_state_e;

endpackage

// File: rtl/mmu_pager_if.sv
// Bus between cpu memory port, mmu_pager and RAM.
// master = cpu side driving requests; slave = the pager.
interface mmu_pager_if #(
  parameter int PA_W = 20
);

  logic [15:0]     vaddr;
  logic [15:0]     cpu_wdata;
  logic            cpu_we;
  logic            cpu_re;
  logic            cpu_be;
  logic            paging_en;
  logic            sup_mode;
  logic            fault_ack;
  logic [PA_W-1:0] paddr;
  logic            ram_we;
  logic            ram_re;
  logic            ram_be;
  logic [15:0]     ram_wdata;
  logic            mmio_hit;
  logic [15:0]     mmio_rdata;
  logic            page_fault;
  logic [1:0]      fault_cause;

  modport master (
    output vaddr, cpu_wdata,
    output cpu_we, cpu_re, cpu_be,
    output paging_en, sup_mode,
    output fault_ack,
    input  paddr, ram_we, ram_re,
    input  ram_be, ram_wdata,
    input  mmio_hit, mmio_rdata,
    input  page_fault, fault_cause
  );

  modport slave (
    input  vaddr, cpu_wdata,
    input  cpu_we, cpu_re, cpu_be,
    input  paging_en, sup_mode,
    input  fault_ack,
    output paddr, ram_we, ram_re,
    output ram_be, ram_wdata,
    output mmio_hit, mmio_rdata,
    output page_fault, fault_cause
  );

endinterface

// File: rtl/mmu_pager_fault_check.sv
// Combinational PTE permission check for one access.
// Takes only the V/W/U flag bits so a TLB can reuse it.
module mmu_fault_check
  import mmu_pkg::*;
(
  input  logic [PTE_U:PTE_V] pte,
  input  logic               we,
  input  logic               re,
  input  logic               sup_mode,
  input  logic               paging_en,
  output fault_cause_e       cause
);

  logic act;
  logic inv;
  logic wp;
  logic pv;

  assign act = paging_en & (we | re);
  assign inv = act & ~pte[PTE_V];
  assign wp  = act & pte[PTE_V]
             & we & ~pte[PTE_W];
  assign pv  = act & pte[PTE_V]
             & ~(we & ~pte[PTE_W])
             & ~sup_mode & ~pte[PTE_U];

  // Exclusive terms encode invalid > wp > privilege
  always_comb begin
    cause = FC_NONE;
    unique case (1'b1)
      inv:     cause = FC_INV;
      wp:      cause = FC_WP;
      pv:      cause = FC_PRIV;
      default: cause = FC_NONE;
    endcase
  end

endmodule

// File: rtl/mmu_pager.sv
// Paging unit: 16-entry PTE file, MMIO window, sticky fault.
// Build option: MMIO_FAR_EN (status register replaces PTE15).
module mmu_pager
  import mmu_pkg::*;
#(
  parameter int          PA_W      = 20,
  parameter logic [15:0] MMIO_BASE = 16'hFFC0,
  parameter logic [15:0] PTE_RESET = 16'h0000
) (
  input logic        clk,
  input logic        reset,
  mmu_pager_if.slave bus
);

  localparam int PPN_W = PA_W - PAGE_SHIFT;
  localparam logic [16:0] MMIO_TOP =
    {1'b0, MMIO_BASE} + 17'd31;

  logic [15:0]      pte_q [16];
  logic [15:0]      far_q;
  logic [15:0]      far_d;
  fault_cause_e     cause_q;
  fault_cause_e     cause_d;
  pf_state_e        state_q;
  pf_state_e        state_d;

  logic [3:0]       vpn;
  logic [3:0]       idx;
  logic             hit;
  logic             acc;
  logic             pte_we;
  logic [PPN_W-1:0] ppn_cur;
  logic [2:0]       flg_cur;
  logic [15:0]      slot;
  fault_cause_e     chk_cause;
  fault_cause_e     cause_now;
  logic             ok;

  assign vpn = bus.vaddr[15:12];
  assign idx = bus.vaddr[4:1];
  assign acc = bus.cpu_we | bus.cpu_re;
  assign hit = (bus.vaddr >= MMIO_BASE)
             && ({1'b0, bus.vaddr} <= MMIO_TOP);

  // PTE fields for the page being translated
  always_comb begin
    ppn_cur = pte_q[vpn][PPN_LSB +: PPN_W];
    flg_cur = pte_q[vpn][PTE_U:PTE_V];
`ifdef MMIO_FAR_EN
    if (vpn == 4'hF) begin
      ppn_cur = PPN_W'(8'h0F);
      flg_cur = 3'b011;
    end
`endif
  end

  mmu_fault_check u_chk (
    .pte       (flg_cur),
    .we        (bus.cpu_we),
    .re        (bus.cpu_re),
    .sup_mode  (bus.sup_mode),
    .paging_en (bus.paging_en),
    .cause     (chk_cause)
  );

  // MMIO is checked on privilege only
  always_comb begin
    cause_now = chk_cause;
    if (hit) begin
      cause_now = (acc & ~bus.sup_mode)
                ? FC_PRIV : FC_NONE;
    end
  end

  assign ok = (cause_now == FC_NONE) & ~hit;

  assign bus.ram_we    = bus.cpu_we & ok;
  assign bus.ram_re    = bus.cpu_re & ok;
  assign bus.ram_be    = bus.cpu_be;
  assign bus.ram_wdata = bus.cpu_wdata;
  assign bus.mmio_hit  = hit;
  assign bus.paddr     =
    (bus.paging_en & ~hit)
      ? {ppn_cur, bus.vaddr[11:0]}
      : PA_W'(bus.vaddr);

  // Addressed MMIO slot for the cpu read mux
  always_comb begin
    slot = pte_q[idx];
`ifdef MMIO_FAR_EN
    if (idx == 4'hF) begin
      slot = {far_q[15:2], cause_q};
    end
`endif
  end

  assign bus.mmio_rdata = hit ? slot : 16'h0000;

`ifdef MMIO_FAR_EN
  assign pte_we = hit & bus.cpu_we
                & bus.sup_mode & (idx != 4'hF);
`else
  assign pte_we = hit & bus.cpu_we
                & bus.sup_mode;
`endif

  // Page table registers, written by supervisor MMIO stores
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        pte_q[i] <= PTE_RESET;
      end
    end else if (pte_we) begin
      pte_q[idx] <= bus.cpu_wdata;
    end
  end

  // Sticky fault state, FAR and cause registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      far_q   <= 16'h0000;
      cause_q <= FC_NONE;
    end else begin
      state_q <= state_d;
      far_q   <= far_d;
      cause_q <= cause_d;
    end
  end

  // Ack clears; otherwise the first fault is latched
  always_comb begin
    state_d = state_q;
    far_d   = far_q;
    cause_d = cause_q;
    if (bus.fault_ack) begin
      state_d = IDLE;
      cause_d = FC_NONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cause_now != FC_NONE) begin
            state_d = FAULTED;
            far_d   = bus.vaddr;
            cause_d = cause_now;
          end
        end
        FAULTED: begin
          state_d = FAULTED;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.page_fault  = (state_q == FAULTED);
  assign bus.fault_cause = cause_q;

endmodule

// File: doc/mmu_pager.md
Name: mmu_pager

Overview:
- Paging unit sitting directly downstream of the cpu's memory port, between the cpu and RAM.
- Consumes the cpu's registered address (MAR), write data and enables; emits the translated physical address and gated RAM strobes.
- Produces the sticky `page_fault` line the cpu's irq_encoder consumes.
- Holds a 16-entry page table in registers, programmed by supervisor stores to an MMIO window; also holds a fault address/cause register.

Parameters:
- PA_W, 20, physical address width; PPN width = PA_W-12.
- MMIO_BASE, 16'hFFC0, base of 32-byte MMIO window.
- PTE_RESET, 16'h0000, reset value of every PTE (all invalid).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- vaddr  in  16  virtual address from cpu (MAR)
- cpu_wdata  in  16  store data from cpu (MDR)
- cpu_we  in  1  store strobe
- cpu_re  in  1  load strobe
- cpu_be  in  1  byte-enable passthrough
- paging_en  in  1  CR bit 2 of the active bank
- sup_mode  in  1  1 = supervisor bank active
- fault_ack  in  1  irq_encoder deassert pulse
- paddr  out  PA_W  physical address to RAM
- ram_we  out  1  gated write strobe
- ram_re  out  1  gated read strobe
- ram_be  out  1  byte-enable to RAM
- ram_wdata  out  16  write data to RAM (= cpu_wdata)
- mmio_hit  out  1  access targets MMIO window; cpu read mux selects mmio_rdata
- mmio_rdata  out  16  MMIO read data
- page_fault  out  1  sticky fault request
- fault_cause  out  2  00 none, 01 invalid, 10 write-protect, 11 privilege

Behaviour:
- PTE format: [15:8] PPN (low PA_W-12 bits used), [3] dirty, [2] user, [1] writable, [0] valid.
- Translation is combinational from vaddr: vpn = vaddr[15:12], offset = vaddr[11:0].
  - paging_en=0: paddr = zero-extended vaddr.
  - paging_en=1: paddr = {PTE[vpn].PPN, offset}.
- MMIO window is MMIO_BASE..MMIO_BASE+31, decoded on vaddr only and never translated.
  - 0x00–0x1E: PTE0..PTE15, word-aligned; index = vaddr[4:1].
  - 0x20 wraps back into the window (5-bit offset) — excluded by the 32-byte size.
  - FAR (faulting vaddr) and cause are read at PTE offsets only when `MMIO_FAR_EN` is defined; otherwise all 16 slots are PTEs.
- MMIO write:
  - sup_mode=1 and cpu_we: PTE updated on the next posedge; ram_we=0.
  - sup_mode=0: MMIO write is a privilege fault; no update.
- MMIO read:
  - mmio_rdata = addressed PTE, combinational; ram_re=0.
  - MMIO reads in user mode also raise a privilege fault.
- Fault check (paging_en=1, non-MMIO, cpu_we|cpu_re):
  - valid=0 → invalid.
  - cpu_we & writable=0 → write-protect.
  - sup_mode=0 & user=0 → privilege.
  - Priority: invalid > write-protect > privilege.
- Faulting access: ram_we and ram_re forced to 0 in the same cycle (combinational gating). On the next posedge:
  - page_fault <= 1;
  - FAR <= vaddr;
  - fault_cause <= cause.
- Sticky rules:
  - page_fault holds until a posedge with fault_ack=1, then clears to 0 with cause 00.
  - A new fault while page_fault=1 is ignored; first fault wins and FAR is not overwritten.
  - fault_ack coincident with a new fault: clear wins; the new access is still blocked.
- cpu_we and cpu_re both high: treated as write for checks.
- Reset asserted, any time, asynchronous:
  - all PTEs = PTE_RESET; FAR = 0; page_fault = 0; fault_cause = 00.
  - Outputs are combinational from inputs, so paddr = vaddr while paging_en=0.
  - Reset mid-fault clears the fault.
- Latency: translation 0 cycles; fault flag 1 cycle; PTE write visible to translation the cycle after the store.

Optional Feature:
- MMIO_FAR_EN defined: PTE15 slot is replaced by a status register, read-only.
  - Read of MMIO_BASE+0x1E returns {FAR[15:2], fault_cause}.
  - Writes to 0x1E are ignored.
  - Only 15 PTEs exist; vpn 15 translates as an identity page (PPN = 0x0F), user=0, writable=1.
- Undefined: 16 PTEs; FAR is internal only; fault_cause remains on its port.

Decomposition:
- Shared package mmu_pkg:
  - PTE bit positions (PTE_V=0, PTE_W=1, PTE_U=2, PTE_D=3, PPN_LSB=8);
  - fault cause codes (FC_NONE, FC_INV, FC_WP, FC_PRIV);
  - page shift constant 12.
- Sub-module mmu_fault_check: combinational (pte, we, re, sup_mode, paging_en) → cause; reused by a future TLB.
- Register file and sticky fault FSM (states IDLE, FAULTED) stay in mmu_pager.

Test Plan:
- Reset, paging_en=1, cpu_re @ vaddr 0x1234 → ram_re=0; next cycle page_fault=1, fault_cause=01, FAR=0x1234.
- sup_mode=1, store 0x0507 to MMIO_BASE+0x02 (PTE1: PPN 0x05, valid, writable, user); then read vaddr 0x1ABC → paddr=0x05ABC, ram_re=1, no fault.
- PTE1=0x0505 (not writable), user store to 0x1000 → ram_we=0, page_fault=1, cause=10. Hold page_fault 3 cycles, then fault_ack → cleared next posedge.
- While faulted, second invalid access to 0x7000 → FAR stays at first address. Same cycle fault_ack plus new fault → page_fault=0 afterward.
- User-mode store to MMIO_BASE → no PTE change, cause=11. paging_en=0 read of 0x8000 → paddr=0x08000.
- Reset asserted mid-fault, asynchronously, between clock edges → page_fault=0 immediately; all PTEs read back 0.
